// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the clock generator, the clock follower and
// the RX/TX shift blocks.
//   I2S_BITS_PER_CH : default number of BCLK rising edges per LRCLK half-frame
//   follow_state_e  : qualification state of the clock follower
//   i2s_channel_e   : LRCLK level meaning (0 = left, 1 = right)
package i2s_pkg;

  localparam int I2S_BITS_PER_CH = 32;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } follow_state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_channel_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, plus a history flop that
// turns the synchronised level into single-cycle rise/fall strobes.
// Ports:
//   clk   : local clock
//   rst   : asynchronous, active-high reset
//   din   : asynchronous input pin
//   level : synchronised level
//   rise  : high for one clk when the synchronised level goes 0->1
//   fall  : high for one clk when the synchronised level goes 1->0
module i2s_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic stable;
  logic hist;

  // The first flop may go metastable; the second gives a clean level and the
  // third remembers the previous clean level so edges can be found by XOR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      hist   <= 1'b0;
    end else begin
      meta   <= din;
      stable <= meta;
      hist   <= stable;
    end
  end

  assign level = stable;
  assign rise  = stable & ~hist;
  assign fall  = ~stable & hist;

endmodule

// File: rtl/i2s_clk_follower.sv
// Slave-side I2S timing recovery. Takes an externally driven BCLK/LRCLK pair,
// brings it into the clk domain and produces the strobes that the RX/TX shift
// logic needs, together with a lock/error monitor that qualifies the framing.
// Ports:
//   clk, rst    : local clock, asynchronous active-high reset
//   bclk_in     : external bit clock (asynchronous)
//   lrclk_in    : external word clock (asynchronous), 0 = left
//   bclk_rise   : one-clk pulse per synchronised BCLK rising edge
//   bclk_fall   : one-clk pulse per synchronised BCLK falling edge
//   bit_idx     : index of the current rise within the half-frame
//   channel     : LRCLK sampled at the latest BCLK rise
//   frame_start : pulse together with bclk_rise when LRCLK goes right->left
//   locked      : framing has been qualified
//   err_pulse   : one-clk pulse on a half-frame length error or BCLK timeout
module i2s_clk_follower
  import i2s_pkg::*;
#(
  parameter int BITS_PER_CH = I2S_BITS_PER_CH,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bclk_in,
  input  logic                           lrclk_in,
  output logic                           bclk_rise,
  output logic                           bclk_fall,
  output logic [$clog2(BITS_PER_CH)-1:0] bit_idx,
  output logic                           channel,
  output logic                           frame_start,
  output logic                           locked,
  output logic                           err_pulse
);

  localparam int IW = $clog2(BITS_PER_CH);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] IDX_MAX     = IW'(BITS_PER_CH - 1);
  localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_FRAMES);
  localparam logic [TW-1:0] TO_LIMIT    = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

  logic bclk_level_unused;
  logic bclk_re;
  logic bclk_fe;
  logic lr_level;
  logic lr_rise_unused;
  logic lr_fall_unused;

  follow_state_e state;
  logic [GW-1:0] good_cnt;
  logic [TW-1:0] to_cnt;
  logic          fs_good;

  logic lr_change;
  logic checking;
  logic fs_event;
  logic len_err;
  logic to_err;
  logic any_err;

  i2s_sync_edge u_bclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bclk_in),
    .level (bclk_level_unused),
    .rise  (bclk_re),
    .fall  (bclk_fe)
  );

  // LRCLK is only ever looked at on a BCLK rise, so only its level is needed.
  i2s_sync_edge u_lrclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (lrclk_in),
    .level (lr_level),
    .rise  (lr_rise_unused),
    .fall  (lr_fall_unused)
  );

  // Everything here is evaluated in the cycle where the internal rise strobe
  // is high, so all outputs derived from it line up with the registered
  // bclk_rise. Length checking is skipped in SEARCH because the first LRCLK
  // change seen after start-up can land anywhere in the half-frame. The
  // timeout fires on the step into TIMEOUT; the counter then saturates, which
  // is what keeps the error from repeating while BCLK stays dead.
  always_comb begin
    lr_change = (lr_level != channel);
    checking  = (state != SEARCH);
    fs_event  = bclk_re && lr_change && (channel == RIGHT);
    len_err   = 1'b0;
    if (bclk_re && checking) begin
      if (lr_change) begin
        len_err = (bit_idx != IDX_MAX);
      end else begin
        len_err = (bit_idx == IDX_MAX);
      end
    end
    to_err  = !bclk_re && checking && (to_cnt == TO_LAST);
    any_err = len_err || to_err;
  end

  // Strobes, channel, bit index and the BCLK watchdog. bit_idx sticks at its
  // maximum when LRCLK fails to toggle so downstream logic never sees a wrap.
  // fs_good marks a checked, error-free frame start for the FSM one cycle on,
  // which makes locked rise the cycle after the qualifying frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_rise   <= 1'b0;
      bclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      channel     <= LEFT;
      bit_idx     <= '0;
      to_cnt      <= '0;
      fs_good     <= 1'b0;
    end else begin
      bclk_rise   <= bclk_re;
      bclk_fall   <= bclk_fe;
      frame_start <= fs_event;
      fs_good     <= fs_event && (state == TRACK) && !any_err;
      if (bclk_re) begin
        channel <= lr_level;
        if (lr_change) begin
          bit_idx <= '0;
        end else if (bit_idx != IDX_MAX) begin
          bit_idx <= bit_idx + IW'(1);
        end
      end
      if (bclk_re) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_LIMIT) begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  // Qualification FSM. The first LRCLK change only tells us where a
  // half-frame boundary is, so it moves to TRACK without being checked. Any
  // error drops straight back to SEARCH; an error in the same cycle as a
  // frame start therefore also cancels that frame's credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEARCH;
      good_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= any_err;
      case (state)
        SEARCH: begin
          if (bclk_re && lr_change) begin
            state    <= TRACK;
            good_cnt <= '0;
          end
        end
        TRACK: begin
          if (any_err) begin
            state    <= SEARCH;
            good_cnt <= '0;
          end else if (fs_good) begin
            good_cnt <= good_cnt + GW'(1);
            if ((good_cnt + GW'(1)) == GOOD_TARGET) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (any_err) begin
            state    <= SEARCH;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state    <= SEARCH;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_clk_follower.sv
// Directed bench for i2s_clk_follower. BCLK is generated as an 8-clk period
// (4 low, 4 high) with LRCLK changing on the falling edge, i.e. 64 rises and
// 512 clk per frame, and the strobes are sampled on the falling clk edge.
module tb_i2s_clk_follower;

  logic       clk = 1'b0;
  logic       rst;
  logic       bclk_in;
  logic       lrclk_in;
  logic       bclk_rise;
  logic       bclk_fall;
  logic [4:0] bit_idx;
  logic       channel;
  logic       frame_start;
  logic       locked;
  logic       err_pulse;

  int   checks   = 0;
  int   failures = 0;
  logic done;

  i2s_clk_follower #(
    .BITS_PER_CH (32),
    .LOCK_FRAMES (4),
    .TIMEOUT     (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bclk_in     (bclk_in),
    .lrclk_in    (lrclk_in),
    .bclk_rise   (bclk_rise),
    .bclk_fall   (bclk_fall),
    .bit_idx     (bit_idx),
    .channel     (channel),
    .frame_start (frame_start),
    .locked      (locked),
    .err_pulse   (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values();
    checkOutput("rst_bclk_rise", 32'(bclk_rise), 0);
    checkOutput("rst_bclk_fall", 32'(bclk_fall), 0);
    checkOutput("rst_bit_idx", 32'(bit_idx), 0);
    checkOutput("rst_channel", 32'(channel), 0);
    checkOutput("rst_frame_start", 32'(frame_start), 0);
    checkOutput("rst_locked", 32'(locked), 0);
    checkOutput("rst_err_pulse", 32'(err_pulse), 0);
  endtask

  // One BCLK period, entered on a negedge: BCLK falls together with the new
  // LRCLK level, stays low 4 clk, rises, stays high 4 clk. The fall strobe is
  // due 3 negedges after the fall, the rise strobe 3 negedges after the rise,
  // and one negedge later every pulse must be gone.
  task automatic applyStimulus(input logic lr, input int exp_idx, input logic exp_fs,
                               input logic exp_err, input logic lock_rise, input logic lock_after);
    logic exp_fall;
    exp_fall = bclk_in;
    bclk_in  = 1'b0;
    lrclk_in = lr;
    repeat (3) @(negedge clk);
    checkOutput("fall_strobe", 32'(bclk_fall), 32'(exp_fall));
    checkOutput("no_rise_at_fall", 32'(bclk_rise), 0);
    @(negedge clk);
    bclk_in = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rise_strobe", 32'(bclk_rise), 1);
    checkOutput("bit_idx", 32'(bit_idx), 32'(exp_idx));
    checkOutput("channel", 32'(channel), 32'(lr));
    checkOutput("frame_start", 32'(frame_start), 32'(exp_fs));
    checkOutput("err_pulse", 32'(err_pulse), 32'(exp_err));
    checkOutput("locked_at_rise", 32'(locked), 32'(lock_rise));
    @(negedge clk);
    checkOutput("rise_width", 32'(bclk_rise), 0);
    checkOutput("fs_width", 32'(frame_start), 0);
    checkOutput("err_width", 32'(err_pulse), 0);
    checkOutput("locked_after", 32'(locked), 32'(lock_after));
  endtask

  // n rises at one LRCLK level; the first rise is the LRCLK change, so the
  // bit index runs 0..n-1 and only the first rise can carry an event.
  task automatic run_half(input logic lr, input int n, input logic fs_first, input logic err_first,
                          input logic lock_rise_first, input logic lock_level);
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        applyStimulus(lr, 0, fs_first, err_first, lock_rise_first, lock_level);
      end else begin
        applyStimulus(lr, k, 1'b0, 1'b0, lock_level, lock_level);
      end
    end
  endtask

  // From TRACK at the end of a right half: four good frames, locked rising
  // the cycle after the fourth checked frame_start and not before.
  task automatic frames_to_lock();
    for (int f = 1; f <= 4; f++) begin
      run_half(1'b0, 32, 1'b1, 1'b0, 1'b0, (f == 4));
      run_half(1'b1, 32, 1'b0, 1'b0, (f == 4), (f == 4));
    end
  endtask

  initial begin
    int early;
    int repeats;
    int rise_cnt;
    int fall_cnt;
    int b2b;
    logic prev_r;
    logic prev_f;

    rst      = 1'b1;
    bclk_in  = 1'b0;
    lrclk_in = 1'b0;
    done     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    $display("[TB] initial acquisition");
    run_half(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    frames_to_lock();

    $display("[TB] short right half");
    run_half(1'b0, 32, 1'b1, 1'b0, 1'b1, 1'b1);
    run_half(1'b1, 31, 1'b0, 1'b0, 1'b1, 1'b1);
    run_half(1'b0, 32, 1'b1, 1'b1, 1'b0, 1'b0);
    run_half(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    frames_to_lock();

    $display("[TB] static LRCLK");
    run_half(1'b0, 32, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 31, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 31, 1'b0, 1'b0, 1'b0, 1'b0);
    run_half(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    frames_to_lock();

    $display("[TB] BCLK stop");
    run_half(1'b0, 32, 1'b1, 1'b0, 1'b1, 1'b1);
    run_half(1'b1, 10, 1'b0, 1'b0, 1'b1, 1'b1);
    early = 0;
    for (int j = 1; j <= 62; j++) begin
      @(negedge clk);
      if (err_pulse) early++;
    end
    checkOutput("timeout_early", early, 0);
    checkOutput("locked_before_timeout", 32'(locked), 1);
    @(negedge clk);
    checkOutput("timeout_pulse", 32'(err_pulse), 1);
    checkOutput("timeout_unlock", 32'(locked), 0);
    repeats = 0;
    repeat (200) begin
      @(negedge clk);
      if (err_pulse) repeats++;
    end
    checkOutput("timeout_repeat", repeats, 0);
    run_half(1'b0, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    run_half(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    frames_to_lock();

    $display("[TB] reset while locked");
    run_half(1'b0, 10, 1'b1, 1'b0, 1'b1, 1'b1);
    rst     = 1'b1;
    bclk_in = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      applyStimulus(1'b0, k, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_half(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    frames_to_lock();

    $display("[TB] random phase BCLK");
    bclk_in = 1'b0;
    repeat (6) @(negedge clk);
    rise_cnt = 0;
    fall_cnt = 0;
    b2b      = 0;
    prev_r   = 1'b0;
    prev_f   = 1'b0;
    fork
      begin
        for (int p = 0; p < 20; p++) begin
          #(35 + $urandom_range(0, 20));
          bclk_in = 1'b1;
          #(35 + $urandom_range(0, 20));
          bclk_in = 1'b0;
        end
        #60;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (bclk_rise) rise_cnt++;
          if (bclk_fall) fall_cnt++;
          if ((bclk_rise && prev_r) || (bclk_fall && prev_f)) b2b++;
          prev_r = bclk_rise;
          prev_f = bclk_fall;
        end
      end
    join
    checkOutput("async_rise_count", rise_cnt, 20);
    checkOutput("async_fall_count", fall_cnt, 20);
    checkOutput("async_back_to_back", b2b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_clk_follower.md
Name: i2s_clk_follower

Overview:
Slave-side counterpart of the I2S clock generator: accepts an externally driven BCLK/LRCLK pair, for example from a codec or another board acting as I2S master.
- Synchronises both clocks into the local clk domain.
- Produces single-cycle BCLK edge strobes, bit index and channel, and a frame-start pulse.
- Qualifies the timing with a lock/error monitor.

Downstream I2S RX/TX shift logic consumes these strobes instead of locally generated ones.

Parameters:
- BITS_PER_CH, 32, BCLK rising edges per LRCLK half-frame; 64 per frame.
- LOCK_FRAMES, 4, consecutive checked good frames required before locked asserts.
- TIMEOUT, 64, clk cycles without bclk_rise before loss of lock; must exceed one BCLK period.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- bclk_in  in  1  external BCLK; asynchronous to clk.
- lrclk_in  in  1  external LRCLK; asynchronous to clk; 0 = left.
- bclk_rise  out  1  one-clk pulse per synchronised BCLK rising edge.
- bclk_fall  out  1  one-clk pulse per synchronised BCLK falling edge.
- bit_idx  out  $clog2(BITS_PER_CH)  index of the current rise within the half-frame.
- channel  out  1  LRCLK value sampled at the latest bclk_rise.
- frame_start  out  1  pulse with bclk_rise when sampled LRCLK goes 1->0.
- locked  out  1  timing qualified.
- err_pulse  out  1  one-clk pulse on a length error or timeout.

Behaviour:
- Reset: all outputs 0, sync/history flops 0, state SEARCH, all counters 0.
- Sync: 2-FF synchroniser per input plus one history flop. Edge = stage2 XOR history.
  - bclk_rise/bclk_fall assert 2-3 clk after the pad transition and last exactly 1 clk.
  - bclk_fall passes through regardless of state.
- LRCLK is sampled only on bclk_rise into channel; change = sampled value != previous channel.
- bit_idx, updated on bclk_rise:
  - change -> 0.
  - otherwise bit_idx+1.
  - Overflow: a rise with no change while bit_idx == BITS_PER_CH-1 is a length error; bit_idx holds at max.
- Length check, applied in TRACK/LOCKED only: on change, the previous bit_idx must equal BITS_PER_CH-1, otherwise length error.
- frame_start fires on a 1->0 change in every state, including SEARCH.
- Timeout counter:
  - cleared on bclk_rise, incremented otherwise, saturating at TIMEOUT.
  - Reaching TIMEOUT while in TRACK/LOCKED is a timeout error, raised once only.
  - Stays silent in SEARCH.
- FSM:
  - SEARCH: first LR change (unchecked) -> TRACK, good_cnt=0.
  - TRACK:
    - each error-free frame_start -> good_cnt+1.
    - good_cnt reaching LOCK_FRAMES -> LOCKED.
    - any error -> SEARCH.
  - LOCKED: any error -> SEARCH.
- locked = (state==LOCKED), registered: high the cycle after the qualifying frame_start, low the cycle after the error.
- err_pulse: 1 clk, the cycle after the error condition.
- Simultaneous error and frame_start: the error wins, and good_cnt does not increment.
- Reset mid-operation: immediate return to reset values; lock must be re-earned from SEARCH.
- Widths: good_cnt is $clog2(LOCK_FRAMES+1); the timeout counter is $clog2(TIMEOUT+1).

Decomposition:
- Shared package i2s_pkg holds:
  - FSM state encoding (SEARCH/TRACK/LOCKED).
  - I2S_BITS_PER_CH=32 default.
  - The LRCLK channel encoding (LEFT=0, RIGHT=1), shared with the clock generator and RX/TX blocks.
- Sub-module i2s_sync_edge: 2-FF synchroniser plus rise/fall detect, instantiated once for BCLK and once for LRCLK. LRCLK uses only the synchronised level.

Test Plan:
- Drive from the I2S clock generator (CLK_DIV=4, rst_n = ~rst) -> bclk_rise every 8 clk, frame_start every 512 clk, bit_idx 0..31 per half, locked rises 1 clk after the 4th checked frame_start, err_pulse never asserts.
- After lock, shorten one half-frame to 31 rises -> err_pulse once, locked=0 next cycle, state SEARCH; relocks after 4 further good frames.
- After lock, hold LRCLK static -> on the 33rd rise err_pulse once, locked=0, bit_idx holds 31.
- After lock, stop BCLK -> err_pulse exactly once 64 clk after the last bclk_rise, locked=0, no repeat pulses while BCLK stays stopped.
- Assert rst mid-frame while locked -> all outputs 0 immediately; after release, locked needs the full SEARCH->TRACK sequence again.
- Toggle bclk_in asynchronously with random phase vs clk -> exactly one bclk_rise and one bclk_fall per BCLK period, never back-to-back pulses.
